csr_exe: RTL and testbench

CSR_EXE -- requirements
Module: csr_exe

---
 rtl/csr_exe.sv | 205 ++++++++++++++++++++
 tb/tb_csr_exe.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/csr_exe.sv
// csr_exe: executes Zicsr instructions (CSRRW/RS/RC and immediate forms)
// once the op reaches the ROB head, then writes the old CSR value back.
//
// Optional feature: define CSR_RO_CHECK_EN to reject writes to read-only
// CSRs (addr[11:10] == 2'b11) with an illegal-instruction exception.
//
// Ports
//   clk, reset_        clock, async active-low reset
//   issue_*            op from issue stage (valid/ready handshake)
//   rob_head           current ROB head tag
//   flush_             active-low pipeline flush (honoured only before READ)
//   csr_re/we/addr/wdata, csr_rdata/fault   CSR file access
//   wb_e/ready/rob_id/data/exp             writeback handshake
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | ready for a new op
// WAIT_HEAD | op latched, waiting until it is the oldest in the ROB
// READ      | csr_re strobe, old value and fault captured
// WRITE     | csr_we strobe with RW/RS/RC result
// RESP      | writeback held until wb_ready

`ifndef AddrWidth
`define AddrWidth 12
`endif
`ifndef DataWidth
`define DataWidth 32
`endif
`ifndef RobDepthBit
`define RobDepthBit 4
`endif

module csr_exe #(
  parameter int ADDR = `AddrWidth,
  parameter int DATA = `DataWidth,
  parameter int ROB  = `RobDepthBit
) (
  input  logic            clk,
  input  logic            reset_,
  input  logic            issue_e,
  output logic            issue_ready,
  input  logic [2:0]      issue_op,
  input  logic [ADDR-1:0] issue_addr,
  input  logic [DATA-1:0] issue_src,
  input  logic            issue_rd_zero,
  input  logic            issue_rs1_zero,
  input  logic [ROB-1:0]  issue_rob_id,
  input  logic [ROB-1:0]  rob_head,
  input  logic            flush_,
  output logic            csr_re,
  output logic            csr_we,
  output logic [ADDR-1:0] csr_addr,
  output logic [DATA-1:0] csr_wdata,
  input  logic [DATA-1:0] csr_rdata,
  input  logic            csr_fault,
  output logic            wb_e,
  input  logic            wb_ready,
  output logic [ROB-1:0]  wb_rob_id,
  output logic [DATA-1:0] wb_data,
  output logic            wb_exp
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_HEAD = 3'd1,
    READ      = 3'd2,
    WRITE     = 3'd3,
    RESP      = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      op_q;
  logic [ADDR-1:0] addr_q;
  logic [DATA-1:0] src_q;
  logic            rd_zero_q;
  logic            rs1_zero_q;
  logic [ROB-1:0]  rob_id_q;
  logic [DATA-1:0] old_q;
  logic            exp_q;

  logic accept;
  logic set_exp;
  logic op_illegal;
  logic op_rw;
  logic op_set_clr;
  logic ro_block;

  // funct3[2] only selects register vs immediate source, already folded into src
  assign op_illegal = (op_q == 3'b000) || (op_q == 3'b100);
  assign op_rw      = (op_q[1:0] == 2'b01);
  assign op_set_clr = op_q[1];

`ifdef CSR_RO_CHECK_EN
  assign ro_block = (addr_q[ADDR-1:ADDR-2] == 2'b11);
`else
  assign ro_block = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    issue_ready = 1'b0;
    csr_re      = 1'b0;
    csr_we      = 1'b0;
    wb_e        = 1'b0;
    set_exp     = 1'b0;
    accept      = 1'b0;
    unique case (state_q)
      IDLE: begin
        issue_ready = 1'b1;
        if (issue_e && flush_) begin
          accept  = 1'b1;
          state_d = WAIT_HEAD;
        end
      end
      WAIT_HEAD: begin
        if (!flush_) begin
          state_d = IDLE;
        end else if (op_illegal) begin
          set_exp = 1'b1;
          state_d = RESP;
        end else if (rob_id_q == rob_head) begin
          if (op_rw && rd_zero_q) begin
            // rd==x0 CSRRW has no read side effect, so the read is skipped
            if (ro_block) begin
              set_exp = 1'b1;
              state_d = RESP;
            end else begin
              state_d = WRITE;
            end
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        csr_re = 1'b1;
        if (csr_fault) begin
          set_exp = 1'b1;
          state_d = RESP;
        end else if (op_set_clr && rs1_zero_q) begin
          state_d = RESP;
        end else if (ro_block) begin
          set_exp = 1'b1;
          state_d = RESP;
        end else begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        csr_we = 1'b1;
        if (csr_fault) set_exp = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        wb_e = 1'b1;
        if (wb_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    csr_wdata = src_q;
    unique case (op_q[1:0])
      2'b10:   csr_wdata = old_q | src_q;
      2'b11:   csr_wdata = old_q & ~src_q;
      default: csr_wdata = src_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q    <= IDLE;
      op_q       <= '0;
      addr_q     <= '0;
      src_q      <= '0;
      rd_zero_q  <= 1'b0;
      rs1_zero_q <= 1'b0;
      rob_id_q   <= '0;
      old_q      <= '0;
      exp_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q       <= issue_op;
        addr_q     <= issue_addr;
        src_q      <= issue_src;
        rd_zero_q  <= issue_rd_zero;
        rs1_zero_q <= issue_rs1_zero;
        rob_id_q   <= issue_rob_id;
        // cleared so a skipped read writes back zero
        old_q      <= '0;
        exp_q      <= 1'b0;
      end
      if (state_q == READ) old_q <= csr_rdata;
      if (set_exp) exp_q <= 1'b1;
    end
  end

  assign csr_addr  = addr_q;
  assign wb_rob_id = rob_id_q;
  assign wb_data   = old_q;
  assign wb_exp    = exp_q && (state_q == RESP);

endmodule

// File: tb/tb_csr_exe.sv
module tb_csr_exe;

  logic        clk = 1'b0;
  logic        reset_ = 1'b0;
  logic        issue_e = 1'b0;
  logic        issue_ready;
  logic [2:0]  issue_op = 3'b000;
  logic [11:0] issue_addr = '0;
  logic [31:0] issue_src = '0;
  logic        issue_rd_zero = 1'b0;
  logic        issue_rs1_zero = 1'b0;
  logic [3:0]  issue_rob_id = '0;
  logic [3:0]  rob_head = '0;
  logic        flush_ = 1'b1;
  logic        csr_re, csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata = '0;
  logic        csr_fault = 1'b0;
  logic        wb_e;
  logic        wb_ready = 1'b1;
  logic [3:0]  wb_rob_id;
  logic [31:0] wb_data;
  logic        wb_exp;

  int errors = 0;
  int checks = 0;
  int re_cnt = 0;
  int we_cnt = 0;
  int both_cnt = 0;
  int re_base, we_base;

  always #5 clk = ~clk;

  csr_exe dut (
    .clk(clk), .reset_(reset_),
    .issue_e(issue_e), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_addr(issue_addr), .issue_src(issue_src),
    .issue_rd_zero(issue_rd_zero), .issue_rs1_zero(issue_rs1_zero),
    .issue_rob_id(issue_rob_id), .rob_head(rob_head), .flush_(flush_),
    .csr_re(csr_re), .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_fault(csr_fault),
    .wb_e(wb_e), .wb_ready(wb_ready), .wb_rob_id(wb_rob_id),
    .wb_data(wb_data), .wb_exp(wb_exp)
  );

  always @(posedge clk) begin
    if (csr_re) re_cnt++;
    if (csr_we) we_cnt++;
    if (csr_re && csr_we) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // drives one issue beat; returns at the negedge after acceptance (WAIT_HEAD)
  task automatic issue(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] src,
                       input logic rdz, input logic rs1z, input logic [3:0] rob);
    issue_e = 1'b1; issue_op = op; issue_addr = addr; issue_src = src;
    issue_rd_zero = rdz; issue_rs1_zero = rs1z; issue_rob_id = rob;
    cyc();
    issue_e = 1'b0;
    re_base = re_cnt; we_base = we_cnt;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_issue_ready", 32'(issue_ready), 32'd1);
    chk("rst_csr_re", 32'(csr_re), 32'd0);
    chk("rst_csr_we", 32'(csr_we), 32'd0);
    chk("rst_wb_e", 32'(wb_e), 32'd0);
    chk("rst_wb_exp", 32'(wb_exp), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_rob_id", 32'(wb_rob_id), 32'd0);
    cyc(); cyc();
    reset_ = 1'b1;
    cyc();

    // CSRRS 0x300 src 0x8 old 0x1800
    rob_head = 4'd3; csr_rdata = 32'h1800;
    issue(3'b010, 12'h300, 32'h8, 1'b0, 1'b0, 4'd3);
    chk("rs_wait_ready", 32'(issue_ready), 32'd0);
    chk("rs_wait_re", 32'(csr_re), 32'd0);
    cyc();
    chk("rs_read_re", 32'(csr_re), 32'd1);
    chk("rs_read_we", 32'(csr_we), 32'd0);
    chk("rs_read_addr", 32'(csr_addr), 32'h300);
    cyc();
    chk("rs_write_we", 32'(csr_we), 32'd1);
    chk("rs_write_re", 32'(csr_re), 32'd0);
    chk("rs_wdata", csr_wdata, 32'h1808);
    cyc();
    chk("rs_wb_e", 32'(wb_e), 32'd1);
    chk("rs_wb_data", wb_data, 32'h1800);
    chk("rs_wb_rob", 32'(wb_rob_id), 32'd3);
    chk("rs_wb_exp", 32'(wb_exp), 32'd0);
    cyc();
    chk("rs_idle_wb_e", 32'(wb_e), 32'd0);
    chk("rs_idle_ready", 32'(issue_ready), 32'd1);

    // CSRRW rd=x0 src 0x55: write only
    rob_head = 4'd4; csr_rdata = 32'hDEAD;
    issue(3'b001, 12'h340, 32'h55, 1'b1, 1'b0, 4'd4);
    cyc();
    chk("rw_we", 32'(csr_we), 32'd1);
    chk("rw_re", 32'(csr_re), 32'd0);
    chk("rw_wdata", csr_wdata, 32'h55);
    cyc();
    chk("rw_wb_e", 32'(wb_e), 32'd1);
    chk("rw_wb_data", wb_data, 32'd0);
    chk("rw_re_count", 32'(re_cnt - re_base), 32'd0);
    cyc();

    // CSRRC rs1=0 old 0xF: read only
    rob_head = 4'd6; csr_rdata = 32'hF;
    issue(3'b011, 12'h305, 32'h0, 1'b0, 1'b1, 4'd6);
    cyc();
    chk("rc_re", 32'(csr_re), 32'd1);
    cyc();
    chk("rc_wb_e", 32'(wb_e), 32'd1);
    chk("rc_wb_data", wb_data, 32'hF);
    chk("rc_we_count", 32'(we_cnt - we_base), 32'd0);
    chk("rc_re_count", 32'(re_cnt - re_base), 32'd1);
    cyc();

    // head mismatch, flush on cycle 3
    rob_head = 4'd2;
    issue(3'b010, 12'h300, 32'h1, 1'b0, 1'b0, 4'd5);
    cyc(); cyc();
    flush_ = 1'b0;
    cyc();
    flush_ = 1'b1;
    chk("fl_ready", 32'(issue_ready), 32'd1);
    cyc(); cyc();
    chk("fl_wb_e", 32'(wb_e), 32'd0);
    chk("fl_strobes", 32'((re_cnt - re_base) + (we_cnt - we_base)), 32'd0);

    // CSRRW to 0xC00 (read-only region)
    rob_head = 4'd7; csr_rdata = 32'h77;
    issue(3'b001, 12'hC00, 32'h12, 1'b0, 1'b0, 4'd7);
    cyc();
    chk("ro_re", 32'(csr_re), 32'd1);
    cyc();
`ifdef CSR_RO_CHECK_EN
    chk("ro_wb_e", 32'(wb_e), 32'd1);
    chk("ro_wb_exp", 32'(wb_exp), 32'd1);
    chk("ro_we_count", 32'(we_cnt - we_base), 32'd0);
`else
    chk("ro_we", 32'(csr_we), 32'd1);
    chk("ro_wdata", csr_wdata, 32'h12);
    cyc();
    chk("ro_wb_exp", 32'(wb_exp), 32'd0);
    chk("ro_wb_data", wb_data, 32'h77);
`endif
    cyc();

    // wb_ready held low 4 cycles in RESP
    rob_head = 4'd1; csr_rdata = 32'hA0; wb_ready = 1'b0;
    issue(3'b110, 12'h300, 32'h1, 1'b0, 1'b0, 4'd1);
    cyc(); cyc(); cyc();
    for (int i = 0; i < 4; i++) begin
      chk("bp_wb_e", 32'(wb_e), 32'd1);
      chk("bp_wb_data", wb_data, 32'hA0);
      chk("bp_wb_rob", 32'(wb_rob_id), 32'd1);
      cyc();
    end
    wb_ready = 1'b1;
    cyc();
    chk("bp_release", 32'(wb_e), 32'd0);

    // fault during READ
    rob_head = 4'd9; csr_rdata = 32'h3; csr_fault = 1'b1;
    issue(3'b010, 12'h7C0, 32'h4, 1'b0, 1'b0, 4'd9);
    cyc();
    chk("ft_re", 32'(csr_re), 32'd1);
    cyc();
    csr_fault = 1'b0;
    chk("ft_wb_exp", 32'(wb_exp), 32'd1);
    chk("ft_we_count", 32'(we_cnt - we_base), 32'd0);
    cyc();

    // illegal funct3 000
    issue(3'b000, 12'h300, 32'h4, 1'b0, 1'b0, 4'd8);
    cyc();
    chk("il_wb_e", 32'(wb_e), 32'd1);
    chk("il_wb_exp", 32'(wb_exp), 32'd1);
    chk("il_strobes", 32'((re_cnt - re_base) + (we_cnt - we_base)), 32'd0);
    cyc();

    // reset pulse while in WRITE
    rob_head = 4'd2;
    issue(3'b001, 12'h340, 32'h9, 1'b1, 1'b0, 4'd2);
    cyc();
    chk("rw2_we", 32'(csr_we), 32'd1);
    #1 reset_ = 1'b0;
    #1;
    chk("rst_mid_we", 32'(csr_we), 32'd0);
    chk("rst_mid_ready", 32'(issue_ready), 32'd1);
    chk("rst_mid_rob", 32'(wb_rob_id), 32'd0);
    cyc();
    reset_ = 1'b1;
    cyc(); cyc();
    chk("rst_mid_we_count", 32'(we_cnt - we_base), 32'd0);
    chk("rst_mid_wb_e", 32'(wb_e), 32'd0);

    chk("re_we_overlap", 32'(both_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
